// File: rtl/dmem_lsu_bridge_if.sv
// Core-side request/response bundle of the load/store bridge.
// master = core memory stage, slave = dmem_lsu_bridge.
interface dmem_lsu_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/dmem_lsu_bridge.sv
// Load/store bridge: RV32I memory-stage request -> 1/2/4 byte beats on a
// byte-wide BRAM with one-cycle synchronous read. Loads are reassembled
// little-endian and sign/zero-extended; one single-cycle response per request.
module dmem_lsu_bridge #(
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  dmem_lsu_bridge_if.slave  core,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [7:0]        mem_dina,
  input  logic [7:0]        mem_douta
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_e;

  state_e state_q, state_d;

  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        nbeats_q, nbeats_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [23:0]       rbuf_q, rbuf_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              mem_ena_q, mem_ena_d;
  logic              mem_wea_q, mem_wea_d;
  logic [ADDR_W-1:0] mem_addra_q, mem_addra_d;
  logic [7:0]        mem_dina_q, mem_dina_d;

  logic [2:0]  req_nbeats;
  logic        req_illegal;
  logic        req_misaligned;
  logic        req_bad;
  logic [31:0] load_word;
  logic [31:0] load_ext;
  logic        unused_addr_hi;

  // Address bits above the BRAM width alias and are deliberately dropped.
  assign unused_addr_hi = ^core.req_addr[31:ADDR_W];

  // Decode width, illegal funct3 and misalignment of the offered request.
  always_comb begin
    req_nbeats  = 3'd1;
    req_illegal = 1'b0;
    case (core.req_funct3[1:0])
      2'd0:    req_nbeats = 3'd1;
      2'd1:    req_nbeats = 3'd2;
      2'd2:    req_nbeats = 3'd4;
      default: req_illegal = 1'b1;
    endcase
    // Loads allow 4/5 (unsigned B/H) but not 6; stores allow nothing above 2.
    if (core.req_funct3[2] && (core.req_we || core.req_funct3[1])) begin
      req_illegal = 1'b1;
    end
    req_misaligned = ((core.req_funct3[1:0] == 2'd1) && core.req_addr[0]) ||
                     ((core.req_funct3[1:0] == 2'd2) && (core.req_addr[1:0] != 2'b00));
    req_bad = req_illegal || req_misaligned;
  end

  // Bytes are shifted in from the top, so after N captures plus the final
  // mem_douta byte the loaded value sits left-justified in load_word.
  always_comb begin
    load_word = {mem_douta, rbuf_q};
    case (f3_q)
      3'd0:    load_ext = {{24{load_word[31]}}, load_word[31:24]};
      3'd4:    load_ext = {24'h000000, load_word[31:24]};
      3'd1:    load_ext = {{16{load_word[31]}}, load_word[31:16]};
      3'd5:    load_ext = {16'h0000, load_word[31:16]};
      3'd2:    load_ext = load_word;
      default: load_ext = '0;
    endcase
  end

  // Next-state logic for the FSM, beat generator and response registers.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    nbeats_d     = nbeats_q;
    we_d         = we_q;
    f3_d         = f3_q;
    wdata_d      = wdata_q;
    rbuf_d       = rbuf_q;
    mem_ena_d    = mem_ena_q;
    mem_wea_d    = mem_wea_q;
    mem_addra_d  = mem_addra_q;
    mem_dina_d   = mem_dina_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (core.req_valid) begin
          we_d     = core.req_we;
          f3_d     = core.req_funct3;
          nbeats_d = req_nbeats;
          cnt_d    = '0;
          rbuf_d   = '0;
          if (req_bad) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            // Beat 0 is launched straight from the accept edge; the store
            // data register keeps only the bytes still to be sent.
            state_d     = ST_BUSY;
            mem_ena_d   = 1'b1;
            mem_wea_d   = core.req_we;
            mem_addra_d = core.req_addr[ADDR_W-1:0];
            mem_dina_d  = core.req_wdata[7:0];
            wdata_d     = {8'h00, core.req_wdata[31:8]};
          end
        end
      end

      ST_BUSY: begin
        cnt_d = cnt_q + 3'd1;
        if ((cnt_q + 3'd1) < nbeats_q) begin
          mem_addra_d = mem_addra_q + ADDR_W'(1);
          mem_dina_d  = wdata_q[7:0];
          wdata_d     = {8'h00, wdata_q[31:8]};
        end else begin
          mem_ena_d = 1'b0;
          mem_wea_d = 1'b0;
        end
        if (!we_q && (cnt_q != 3'd0)) begin
          rbuf_d = {mem_douta, rbuf_q[23:8]};
        end
        // Loads stay one extra cycle to catch the last read byte.
        if (we_q ? ((cnt_q + 3'd1) == nbeats_q) : (cnt_q == nbeats_q)) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = we_q ? '0 : load_ext;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      nbeats_q     <= '0;
      we_q         <= 1'b0;
      f3_q         <= '0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_ena_q    <= 1'b0;
      mem_wea_q    <= 1'b0;
      mem_addra_q  <= '0;
      mem_dina_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nbeats_q     <= nbeats_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      wdata_q      <= wdata_d;
      rbuf_q       <= rbuf_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_ena_q    <= mem_ena_d;
      mem_wea_q    <= mem_wea_d;
      mem_addra_q  <= mem_addra_d;
      mem_dina_q   <= mem_dina_d;
    end
  end

  assign core.req_ready  = (state_q == ST_IDLE) && !rst;
  assign core.resp_valid = resp_valid_q;
  assign core.resp_err   = resp_err_q;
  assign core.resp_rdata = resp_rdata_q;
  assign mem_ena         = mem_ena_q;
  assign mem_wea         = mem_wea_q;
  assign mem_addra       = mem_addra_q;
  assign mem_dina        = mem_dina_q;

endmodule

// File: tb/tb_dmem_lsu_bridge.sv
// Bench for dmem_lsu_bridge: behavioural BRAM plus a request-level byte-array
// reference model; directed scenarios followed by randomized requests.
module tb_dmem_lsu_bridge;
  localparam int unsigned AW       = 13;
  localparam int unsigned MEM_SIZE = 1 << AW;

  logic          clk;
  logic          rst;
  logic          mem_ena;
  logic          mem_wea;
  logic [AW-1:0] mem_addra;
  logic [7:0]    mem_dina;
  logic [7:0]    mem_douta;

  logic [7:0] bram    [MEM_SIZE];
  logic [7:0] ref_mem [MEM_SIZE];

  int checks   = 0;
  int failures = 0;

  dmem_lsu_bridge_if bus ();

  dmem_lsu_bridge #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .core      (bus),
    .mem_ena   (mem_ena),
    .mem_wea   (mem_wea),
    .mem_addra (mem_addra),
    .mem_dina  (mem_dina),
    .mem_douta (mem_douta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int unsigned i);
    return 8'((i * 37 + 11) ^ (i >> 5));
  endfunction

  // Byte-wide BRAM, not reset, one-cycle read latency.
  initial begin
    for (int i = 0; i < int'(MEM_SIZE); i++) bram[i] = init_byte(i);
    forever begin
      @(posedge clk);
      if (mem_ena) begin
        if (mem_wea) bram[mem_addra] <= mem_dina;
        mem_douta <= bram[mem_addra];
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
  endtask

  task automatic scramble();
    bus.req_we     = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
  endtask

  // One complete request: predict from the reference model, then check every
  // cycle from cycle 0 until the cycle after the response.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] obs_rd);
    int unsigned n;
    int unsigned lat;
    int unsigned base;
    logic        bad;
    logic [31:0] exp_rd;

    base = int'(addr[AW-1:0]);
    bad  = 1'b0;
    case (f3)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd2:       n = 4;
      default:    begin n = 0; bad = 1'b1; end
    endcase
    if (we && f3 > 3'd2) bad = 1'b1;
    if (n == 2 && addr[0]) bad = 1'b1;
    if (n == 4 && addr[1:0] != 2'b00) bad = 1'b1;
    if (bad) n = 0;
    lat    = bad ? 0 : (we ? n : n + 1);
    exp_rd = '0;
    if (!bad && !we) begin
      for (int k = 0; k < int'(n); k++)
        exp_rd = exp_rd | (32'(ref_mem[(base + k) % MEM_SIZE]) << (8 * k));
      if (f3 == 3'd0 && exp_rd[7])  exp_rd = exp_rd | 32'hFFFF_FF00;
      if (f3 == 3'd1 && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF_0000;
    end
    if (!bad && we) begin
      for (int k = 0; k < int'(n); k++)
        ref_mem[(base + k) % MEM_SIZE] = 8'(wd >> (8 * k));
    end

    obs_rd = 'x;
    @(negedge clk);
    chk("ready_before", 32'(bus.req_ready), 32'd1);
    drive(we, f3, addr, wd);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    scramble();
    for (int c = 0; c <= int'(lat) + 1; c++) begin
      @(negedge clk);
      chk("ready", 32'(bus.req_ready), (c > int'(lat)) ? 32'd1 : 32'd0);
      chk("mem_ena", 32'(mem_ena), (c < int'(n)) ? 32'd1 : 32'd0);
      if (c < int'(n)) begin
        chk("mem_wea", 32'(mem_wea), 32'(we));
        chk("mem_addra", 32'(mem_addra), 32'((base + c) % MEM_SIZE));
        if (we) chk("mem_dina", 32'(mem_dina), 32'(8'(wd >> (8 * c))));
      end else begin
        chk("mem_wea_idle", 32'(mem_wea), 32'd0);
      end
      chk("resp_valid", 32'(bus.resp_valid), (c == int'(lat)) ? 32'd1 : 32'd0);
      if (c == int'(lat)) begin
        chk("resp_err", 32'(bus.resp_err), 32'(bad));
        chk("resp_rdata", bus.resp_rdata, exp_rd);
        obs_rd = bus.resp_rdata;
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] hi;
    logic        we;
    logic [2:0]  f3;

    for (int i = 0; i < int'(MEM_SIZE); i++) ref_mem[i] = init_byte(i);

    // Reset with a legal request offered: reset must win.
    rst           = 1'b1;
    bus.req_valid = 1'b1;
    drive(1'b1, 3'd0, 32'h0000_0007, 32'h0000_00AA);
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
      chk("rst_mem_ena", 32'(mem_ena), 32'd0);
      chk("rst_mem_wea", 32'(mem_wea), 32'd0);
      chk("rst_mem_addra", 32'(mem_addra), 32'd0);
      chk("rst_mem_dina", 32'(mem_dina), 32'd0);
    end
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("post_rst_no_accept", 32'(mem_ena), 32'd0);
    chk("post_rst_no_resp", 32'(bus.resp_valid), 32'd0);

    // SW / LW round trip.
    do_req(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, rd);
    chk("sw_bram", {bram[16'h13], bram[16'h12], bram[16'h11], bram[16'h10]}, 32'hDEAD_BEEF);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, rd);
    chk("lw_deadbeef", rd, 32'hDEAD_BEEF);

    // Byte store, signed and unsigned byte loads.
    do_req(1'b1, 3'd0, 32'h13, 32'h0000_0080, rd);
    do_req(1'b0, 3'd0, 32'h13, 32'h0, rd);
    chk("lb_sext", rd, 32'hFFFF_FF80);
    do_req(1'b0, 3'd4, 32'h13, 32'h0, rd);
    chk("lbu_zext", rd, 32'h0000_0080);

    // Halfword store, signed and unsigned halfword loads.
    do_req(1'b1, 3'd1, 32'h22, 32'h0000_8001, rd);
    do_req(1'b0, 3'd1, 32'h22, 32'h0, rd);
    chk("lh_sext", rd, 32'hFFFF_8001);
    do_req(1'b0, 3'd5, 32'h22, 32'h0, rd);
    chk("lhu_zext", rd, 32'h0000_8001);
    chk("sh_keep_24", 32'(bram[16'h24]), 32'(init_byte(32'h24)));
    chk("sh_keep_25", 32'(bram[16'h25]), 32'(init_byte(32'h25)));

    // Error paths, then a normal store.
    do_req(1'b0, 3'd2, 32'h02, 32'h0, rd);
    do_req(1'b1, 3'd1, 32'h01, 32'h1234_5678, rd);
    do_req(1'b0, 3'd3, 32'h30, 32'h0, rd);
    do_req(1'b1, 3'd2, 32'h50, 32'hCAFE_F00D, rd);
    chk("sw_after_err", {bram[16'h53], bram[16'h52], bram[16'h51], bram[16'h50]}, 32'hCAFE_F00D);

    // Reset in the middle of a SW: only beats 0 and 1 reach the BRAM.
    @(negedge clk);
    drive(1'b1, 3'd2, 32'h40, 32'h4433_2211);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    scramble();
    @(negedge clk);
    chk("abort_c0_ena", 32'(mem_ena), 32'd1);
    chk("abort_c0_addr", 32'(mem_addra), 32'h40);
    chk("abort_c0_dina", 32'(mem_dina), 32'h11);
    @(negedge clk);
    chk("abort_c1_addr", 32'(mem_addra), 32'h41);
    chk("abort_c1_dina", 32'(mem_dina), 32'h22);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    ref_mem[32'h40] = 8'h11;
    ref_mem[32'h41] = 8'h22;
    @(negedge clk);
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_ena", 32'(mem_ena), 32'd0);
    chk("abort_wea", 32'(mem_wea), 32'd0);
    repeat (4) begin
      chk("abort_no_resp", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
    end
    do_req(1'b0, 3'd2, 32'h40, 32'h0, rd);
    chk("abort_lw", rd, {init_byte(32'h43), init_byte(32'h42), 8'h22, 8'h11});

    // req_valid held high across SW then LW: LW accepted right after SW's RESP.
    data = $urandom;
    for (int k = 0; k < 4; k++) ref_mem[32'h80 + k] = 8'(data >> (8 * k));
    @(negedge clk);
    drive(1'b1, 3'd2, 32'h80, data);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b0, 3'd2, 32'h80, 32'h0);
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      chk("b2b_resp_valid", 32'(bus.resp_valid), (c == 4 || c == 11) ? 32'd1 : 32'd0);
      chk("b2b_ready", 32'(bus.req_ready), (c == 5 || c == 12) ? 32'd1 : 32'd0);
      if (c == 6) begin
        chk("b2b_lw_beat0", {31'd0, mem_ena & ~mem_wea}, 32'd1);
        chk("b2b_lw_addr", 32'(mem_addra), 32'h80);
        bus.req_valid = 1'b0;
      end
      if (c == 11) chk("b2b_lw_data", bus.resp_rdata, data);
    end

    // Randomized requests, including aliased high address bits and bad codes.
    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        f3 = 3'($urandom);
      end else if (we) begin
        f3 = 3'($urandom_range(0, 2));
      end else begin
        case ($urandom_range(0, 4))
          0:       f3 = 3'd0;
          1:       f3 = 3'd1;
          2:       f3 = 3'd2;
          3:       f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end
      addr = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) addr = addr & 32'hFFFF_FFFC;
      hi   = $urandom;
      if ($urandom_range(0, 1) == 1) addr = addr | (hi & 32'hFFFF_E000);
      do_req(we, f3, addr, $urandom, rd);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
